// File: rtl/data_collector_sched.sv
// Collector sequencer: one open/capture/drain/close FSM per channel, a
// one-entry sample buffer per channel, and a round-robin arbiter feeding a
// single registered write port drained with valid/ready.
module data_collector_sched #(
   parameter int G_NB_COLLECTOR = 2,
   parameter int G_DATA_WIDTH   = 32,
   parameter int G_ID_WIDTH     = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [G_NB_COLLECTOR-1:0]              i_start_collect,
   input  logic [G_NB_COLLECTOR-1:0]              i_stop_collect,
   input  logic [G_NB_COLLECTOR-1:0]              i_data_valid,
   input  logic [G_NB_COLLECTOR*G_DATA_WIDTH-1:0] i_data,
   output logic [G_NB_COLLECTOR-1:0]              o_init_file,
   input  logic [G_NB_COLLECTOR-1:0]              i_file_is_init,
   output logic [G_NB_COLLECTOR-1:0]              o_close_file,
   output logic                                   o_wr_valid,
   output logic [G_ID_WIDTH-1:0]                  o_wr_chan,
   output logic [G_DATA_WIDTH-1:0]                o_wr_data,
   input  logic                                   i_wr_ready,
   output logic [G_NB_COLLECTOR-1:0]              o_busy,
   output logic [G_NB_COLLECTOR-1:0]              o_overflow
);

   localparam int N = G_NB_COLLECTOR;
   localparam int W = G_DATA_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPENING,
      ST_COLLECT,
      ST_DRAIN,
      ST_CLOSING
   } chan_state_t;

   chan_state_t st_q [N];
   chan_state_t st_d [N];

   logic [N-1:0] stop_lat_q;
   logic [N-1:0] stop_lat_d;
   logic [N-1:0] open_req;
   logic [N-1:0] init_p1;
   logic [N-1:0] ovf_q;
   logic [N-1:0] drain_done;
   logic [N-1:0] push;
   logic [N-1:0] drop;
   logic [N-1:0] load_buf;
   logic [N-1:0] grant;
   logic [N-1:0] sel;

   // stage p0: per-channel sample buffer
   logic [N-1:0] vld_p0;
   logic [W-1:0] data_p0 [N];

   // stage p1: shared write-port register
   logic                  vld_p1;
   logic [G_ID_WIDTH-1:0] chan_p1;
   logic [W-1:0]          data_p1;

   logic [G_ID_WIDTH-1:0] rr_q;
   logic [G_ID_WIDTH-1:0] win_idx;
   logic [G_ID_WIDTH-1:0] rr_next;
   logic [W-1:0]          win_data;
   logic                  found;
   logic                  load_out;
   int                    off;

   // Buffer push/drop decisions and drain-complete detection per channel
   always_comb begin
      push       = '0;
      drop       = '0;
      load_buf   = '0;
      drain_done = '0;
      for (int k = 0; k < N; k++) begin
         push[k]       = i_data_valid[k] && (st_q[k] == ST_COLLECT);
         drop[k]       = push[k] && vld_p0[k] && !grant[k];
         load_buf[k]   = push[k] && !drop[k];
         drain_done[k] = !vld_p0[k] && !(vld_p1 && (chan_p1 == G_ID_WIDTH'(k)));
      end
   end

   // Round-robin search from rr_q over full buffers; output register reloads when empty or accepted
   always_comb begin
      load_out = !vld_p1 || i_wr_ready;
      found    = 1'b0;
      sel      = '0;
      win_idx  = '0;
      win_data = '0;
      rr_next  = rr_q;
      off      = 0;
      for (int i = 0; i < N; i++) begin
         off = int'(rr_q) + i;
         if (off >= N) begin
            off = off - N;
         end
         for (int k = 0; k < N; k++) begin
            if (!found && vld_p0[k] && (off == k)) begin
               found    = 1'b1;
               sel[k]   = 1'b1;
               win_idx  = G_ID_WIDTH'(k);
               win_data = data_p0[k];
               rr_next  = (k == N - 1) ? '0 : G_ID_WIDTH'(k + 1);
            end
         end
      end
      grant = load_out ? sel : '0;
   end

   // Channel FSM next-state: open, capture, drain, close
   always_comb begin
      open_req   = '0;
      stop_lat_d = stop_lat_q;
      for (int k = 0; k < N; k++) begin
         st_d[k] = st_q[k];
         case (st_q[k])
            ST_IDLE: begin
               if (i_start_collect[k] && !i_stop_collect[k]) begin
                  st_d[k]       = ST_OPENING;
                  open_req[k]   = 1'b1;
                  stop_lat_d[k] = 1'b0;
               end
            end
            ST_OPENING: begin
               if (i_stop_collect[k]) begin
                  stop_lat_d[k] = 1'b1;
               end
               if (i_file_is_init[k]) begin
                  st_d[k] = (stop_lat_q[k] || i_stop_collect[k]) ? ST_DRAIN : ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (i_stop_collect[k]) begin
                  st_d[k] = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done[k]) begin
                  st_d[k] = ST_CLOSING;
               end
            end
            ST_CLOSING: begin
               st_d[k] = ST_IDLE;
            end
            default: begin
               st_d[k] = ST_IDLE;
            end
         endcase
      end
   end

   // Control state: FSMs, open pulse, sticky overflow, buffer-full flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            st_q[k] <= ST_IDLE;
         end
         stop_lat_q <= '0;
         init_p1    <= '0;
         ovf_q      <= '0;
         vld_p0     <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            st_q[k] <= st_d[k];
         end
         stop_lat_q <= stop_lat_d;
         init_p1    <= open_req;
         ovf_q      <= (ovf_q | drop) & ~open_req;
         vld_p0     <= push | (vld_p0 & ~grant);
      end
   end

   // stage p0 data: a pushed sample takes the slot (also when popped the same cycle)
   always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (load_buf[k]) begin
            data_p0[k] <= i_data[k*W +: W];
         end
      end
   end

   // stage p1: write-port register, held while valid and not ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         chan_p1 <= '0;
         data_p1 <= '0;
         rr_q    <= '0;
      end else if (load_out) begin
         vld_p1 <= found;
         if (found) begin
            chan_p1 <= win_idx;
            data_p1 <= win_data;
            rr_q    <= rr_next;
         end
      end
   end

   // Status outputs decoded from channel state
   always_comb begin
      o_busy       = '0;
      o_close_file = '0;
      for (int k = 0; k < N; k++) begin
         o_busy[k]       = (st_q[k] != ST_IDLE);
         o_close_file[k] = (st_q[k] == ST_CLOSING);
      end
   end

   assign o_init_file = init_p1;
   assign o_overflow  = ovf_q;
   assign o_wr_valid  = vld_p1;
   assign o_wr_chan   = chan_p1;
   assign o_wr_data   = data_p1;

endmodule
